// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit shift register: hold / shift right / shift left / parallel load,
// with a saturating shift counter. Define UNIV_SHIFT_REG_ROTATE_EN to rotate instead of shift.
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}},
    localparam int                CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             sync_reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] D,
    input  logic             ser_in_r,
    input  logic             ser_in_l,
    output logic [WIDTH-1:0] Q,
    output logic             ser_out_r,
    output logic             ser_out_l,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             drained
);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic fill_r;
    logic fill_l;

`ifdef UNIV_SHIFT_REG_ROTATE_EN
    // Rotation recirculates the bit falling off the opposite end.
    assign fill_r = Q[0];
    assign fill_l = Q[WIDTH-1];
`else
    assign fill_r = ser_in_r;
    assign fill_l = ser_in_l;
`endif

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            Q         <= RESET_VAL;
            shift_cnt <= '0;
        end else if (en) begin
            case (mode)
                MODE_SHR: begin
                    Q <= {fill_r, Q[WIDTH-1:1]};
                    if (shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
                end
                MODE_SHL: begin
                    Q <= {Q[WIDTH-2:0], fill_l};
                    if (shift_cnt != CNT_MAX) shift_cnt <= shift_cnt + 1'b1;
                end
                MODE_LOAD: begin
                    Q         <= D;
                    shift_cnt <= '0;
                end
                MODE_HOLD: begin
                    Q         <= Q;
                    shift_cnt <= shift_cnt;
                end
                default: begin
                    Q         <= Q;
                    shift_cnt <= shift_cnt;
                end
            endcase
        end
    end

    assign ser_out_r = Q[0];
    assign ser_out_l = Q[WIDTH-1];
    assign drained   = (shift_cnt == CNT_MAX);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg: directed test-plan cases plus random
// stimulus against an integer-arithmetic reference model.
module tb_univ_shift_reg;

    localparam int         WIDTH = 8;
    localparam int         CNT_W = $clog2(WIDTH + 1);
    localparam logic [7:0] RV    = 8'hA5;

    logic             clk = 1'b0;
    logic             sync_reset_n;
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] D;
    logic             ser_in_r;
    logic             ser_in_l;
    logic [WIDTH-1:0] Q;
    logic             ser_out_r;
    logic             ser_out_l;
    logic [CNT_W-1:0] shift_cnt;
    logic             drained;

    int n_chk = 0;
    int n_bad = 0;

    int mq;
    int mc;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
        .clk(clk), .sync_reset_n(sync_reset_n), .en(en), .mode(mode), .D(D),
        .ser_in_r(ser_in_r), .ser_in_l(ser_in_l), .Q(Q),
        .ser_out_r(ser_out_r), .ser_out_l(ser_out_l),
        .shift_cnt(shift_cnt), .drained(drained)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: register as an integer 0..255, counter as an integer 0..WIDTH.
    task automatic model_edge(input logic rn, input logic e, input logic [1:0] m,
                              input logic [7:0] d, input logic sr, input logic sl);
        int in_bit;
        if (!rn) begin
            mq = int'(RV);
            mc = 0;
        end else if (e) begin
            if (m == 2'd1) begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                in_bit = mq % 2;
`else
                in_bit = int'(sr);
`endif
                mq = (mq / 2) + in_bit * 128;
                mc = (mc < WIDTH) ? mc + 1 : WIDTH;
            end else if (m == 2'd2) begin
`ifdef UNIV_SHIFT_REG_ROTATE_EN
                in_bit = mq / 128;
`else
                in_bit = int'(sl);
`endif
                mq = ((mq * 2) % 256) + in_bit;
                mc = (mc < WIDTH) ? mc + 1 : WIDTH;
            end else if (m == 2'd3) begin
                mq = int'(d);
                mc = 0;
            end
        end
    endtask

    task automatic step(input logic rn, input logic e, input logic [1:0] m,
                        input logic [7:0] d, input logic sr, input logic sl);
        sync_reset_n = rn;
        en           = e;
        mode         = m;
        D            = d;
        ser_in_r     = sr;
        ser_in_l     = sl;
        @(posedge clk);
        model_edge(rn, e, m, d, sr, sl);
        @(negedge clk);
        check("q",         32'(Q),         32'(mq));
        check("shift_cnt", 32'(shift_cnt), 32'(mc));
        check("drained",   32'(drained),   32'(mc == WIDTH));
        check("ser_out_r", 32'(ser_out_r), 32'(mq % 2));
        check("ser_out_l", 32'(ser_out_l), 32'(mq / 128));
    endtask

    initial begin
        mq = 0;
        mc = 0;

        // Reset beats a simultaneous load.
        step(1'b0, 1'b1, 2'b11, 8'hFF, 1'b0, 1'b0);
        check("tp_reset_q",   32'(Q),         32'h A5);
        check("tp_reset_cnt", 32'(shift_cnt), 32'd0);
        check("tp_reset_drn", 32'(drained),   32'd0);

        step(1'b1, 1'b1, 2'b11, 8'h81, 1'b0, 1'b0);
`ifdef UNIV_SHIFT_REG_ROTATE_EN
        step(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        check("tp_rot_r_q", 32'(Q), 32'h C0);
        step(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b0);
        check("tp_rot_l_q",   32'(Q),         32'h 03);
        check("tp_rot_l_cnt", 32'(shift_cnt), 32'd3);
`else
        step(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        check("tp_shr_q",    32'(Q),         32'h 40);
        check("tp_shr_sor",  32'(ser_out_r), 32'd0);
        check("tp_shr_cnt",  32'(shift_cnt), 32'd1);
        step(1'b1, 1'b1, 2'b10, 8'h00, 1'b0, 1'b1);
        check("tp_shl_q",    32'(Q),         32'h 81);
        check("tp_shl_cnt",  32'(shift_cnt), 32'd2);

        // Drain to saturation and beyond.
        step(1'b1, 1'b1, 2'b11, 8'hC3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 2'b01, 8'h00, 1'b0, 1'b0);
        check("tp_drain_q",   32'(Q),         32'h 00);
        check("tp_drain_cnt", 32'(shift_cnt), 32'd8);
        check("tp_drain_flg", 32'(drained),   32'd1);
        for (int i = 0; i < 2; i++) step(1'b1, 1'b1, 2'b01, 8'h00, 1'b1, 1'b0);
        check("tp_sat_cnt",   32'(shift_cnt), 32'd8);
        check("tp_sat_q",     32'(Q),         32'h C0);
        step(1'b1, 1'b1, 2'b11, 8'h01, 1'b0, 1'b0);
        check("tp_reload_cnt", 32'(shift_cnt), 32'd0);
        check("tp_reload_drn", 32'(drained),   32'd0);
`endif

        // Enable low holds everything; mode 00 holds too.
        step(1'b1, 1'b1, 2'b11, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1);
        check("tp_en0_q",   32'(Q),         32'h 3C);
        check("tp_en0_cnt", 32'(shift_cnt), 32'd0);
        step(1'b1, 1'b1, 2'b00, 8'hFF, 1'b1, 1'b1);
        check("tp_hold_q",  32'(Q),         32'h 3C);

        // Reset ignores en and discards a shift sequence in progress.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 2'b10, 8'h00, 1'b1, 1'b1);
        check("tp_pre_rst_cnt", 32'(shift_cnt), 32'd4);
        step(1'b0, 1'b0, 2'b01, 8'h00, 1'b1, 1'b1);
        check("tp_rst_en0_q",   32'(Q),         32'h A5);
        check("tp_rst_en0_cnt", 32'(shift_cnt), 32'd0);

        // Random traffic, shift-heavy so saturation is reached often.
        for (int i = 0; i < 600; i++) begin
            logic       rn;
            logic       e;
            logic [1:0] m;
            rn = ($urandom_range(0, 31) != 0);
            e  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 9))
                0:       m = 2'b00;
                1:       m = 2'b11;
                2, 3, 4, 5: m = 2'b01;
                default: m = 2'b10;
            endcase
            step(rn, e, m, 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
